key_conditioner: RTL and testbench

//   Conditions the raw active-low DE2 pushbuttons before the reaction-timer game logic uses them.
//   - Synchronises each raw KEY into the CLOCK_50 domain.
//   - Debounces each key and presents a clean active-high level.
//   - Generates one-cycle press, release and long-hold strobes.
//   The game FSM acts on these strobes, so every physical press counts exactly once.

---
 rtl/key_conditioner.sv | 141 ++++++++++++++
 tb/tb_key_conditioner.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: synchronises, debounces and strobes each active-low DE2 KEY.
// Each key has its own debounce/hold FSM, so simultaneous presses never interact.
module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_hold
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_FIRE = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_MAX  = HW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] w_pressed;

    // Sync flops reset to "released" so a key held through reset looks like a fresh press.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= KEY;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = ~r_sync2;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        state_t          r_state,   w_state_nxt;
        logic [DW-1:0]   r_dcnt,    w_dcnt_nxt;
        logic [HW-1:0]   r_hcnt,    w_hcnt_nxt;
        logic            r_level,   w_level_nxt;
        logic            r_press,   w_press_nxt;
        logic            r_release, w_release_nxt;
        logic            r_hold,    w_hold_nxt;

        always_comb begin
            w_state_nxt   = r_state;
            w_dcnt_nxt    = r_dcnt;
            w_hcnt_nxt    = r_hcnt;
            w_level_nxt   = r_level;
            w_press_nxt   = 1'b0;
            w_release_nxt = 1'b0;
            w_hold_nxt    = 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pressed[g]) begin
                        w_state_nxt = PRESS_WAIT;
                        w_dcnt_nxt  = DW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!w_pressed[g]) begin
                        w_state_nxt = IDLE;
                        w_dcnt_nxt  = '0;
                    end else if (r_dcnt == DCNT_LAST) begin
                        w_state_nxt = PRESSED;
                        w_dcnt_nxt  = '0;
                        w_hcnt_nxt  = '0;
                        w_level_nxt = 1'b1;
                        w_press_nxt = 1'b1;
                    end else begin
                        w_dcnt_nxt = r_dcnt + DW'(1);
                    end
                end
                // Saturating at HCNT_MAX is what limits key_hold to one pulse per press.
                PRESSED: begin
                    if (!w_pressed[g]) begin
                        w_state_nxt = RELEASE_WAIT;
                        w_dcnt_nxt  = DW'(1);
                    end else if (r_hcnt == HCNT_FIRE) begin
                        w_hcnt_nxt = HCNT_MAX;
                        w_hold_nxt = 1'b1;
                    end else if (r_hcnt != HCNT_MAX) begin
                        w_hcnt_nxt = r_hcnt + HW'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (w_pressed[g]) begin
                        w_state_nxt = PRESSED;
                        w_dcnt_nxt  = '0;
                    end else if (r_dcnt == DCNT_LAST) begin
                        w_state_nxt   = IDLE;
                        w_dcnt_nxt    = '0;
                        w_hcnt_nxt    = '0;
                        w_level_nxt   = 1'b0;
                        w_release_nxt = 1'b1;
                    end else begin
                        w_dcnt_nxt = r_dcnt + DW'(1);
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end

        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                r_state   <= IDLE;
                r_dcnt    <= '0;
                r_hcnt    <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_hold    <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_dcnt    <= w_dcnt_nxt;
                r_hcnt    <= w_hcnt_nxt;
                r_level   <= w_level_nxt;
                r_press   <= w_press_nxt;
                r_release <= w_release_nxt;
                r_hold    <= w_hold_nxt;
            end
        end

        assign key_level[g]   = r_level;
        assign key_press[g]   = r_press;
        assign key_release[g] = r_release;
        assign key_hold[g]    = r_hold;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/hold windows.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_key_conditioner;

    localparam int NUM_KEYS = 4;

    logic                CLOCK_50;
    logic                RESET_N;
    logic [NUM_KEYS-1:0] KEY;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_hold;

    int checks = 0;
    int errors = 0;

    key_conditioner #(
        .NUM_KEYS       (NUM_KEYS),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .KEY        (KEY),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_hold   (key_hold)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic applyStimulus(input logic [NUM_KEYS-1:0] keys);
        KEY = keys;
    endtask

    task automatic checkOutput(input string tag, input logic [NUM_KEYS-1:0] observed,
                               input logic [NUM_KEYS-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [NUM_KEYS-1:0] expLevel,
                            input logic [NUM_KEYS-1:0] expPress,
                            input logic [NUM_KEYS-1:0] expRelease,
                            input logic [NUM_KEYS-1:0] expHold);
        checkOutput({tag, " level"},   key_level,   expLevel);
        checkOutput({tag, " press"},   key_press,   expPress);
        checkOutput({tag, " release"}, key_release, expRelease);
        checkOutput({tag, " hold"},    key_hold,    expHold);
    endtask

    logic [0:11] bouncePat;

    initial begin
        applyStimulus(4'b1111);
        RESET_N = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        checkAll("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        checkAll("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Clean press of KEY[1], then clean release
        applyStimulus(4'b1101);
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLOCK_50);
            checkAll($sformatf("t1 press c%0d", i), (i >= 6) ? 4'b0010 : 4'b0000,
                     (i == 6) ? 4'b0010 : 4'b0000, 4'b0000, 4'b0000);
        end
        applyStimulus(4'b1111);
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLOCK_50);
            checkAll($sformatf("t1 release c%0d", i), (i < 6) ? 4'b0010 : 4'b0000,
                     4'b0000, (i == 6) ? 4'b0010 : 4'b0000, 4'b0000);
        end

        // Bounce on KEY[0]: low 3, high 2, low 2, high
        bouncePat = 12'b000110011111;
        for (int i = 0; i < 12; i++) begin
            applyStimulus({3'b111, bouncePat[i]});
            @(negedge CLOCK_50);
            checkAll($sformatf("t2 bounce c%0d", i), 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        repeat (4) @(negedge CLOCK_50);
        checkAll("t2 settled", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Long hold on KEY[2]
        applyStimulus(4'b1011);
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLOCK_50);
            checkAll($sformatf("t3 hold c%0d", i), (i >= 6) ? 4'b0100 : 4'b0000,
                     (i == 6) ? 4'b0100 : 4'b0000, 4'b0000, (i == 16) ? 4'b0100 : 4'b0000);
        end
        applyStimulus(4'b1111);
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLOCK_50);
            checkAll($sformatf("t3 release c%0d", i), (i < 6) ? 4'b0100 : 4'b0000,
                     4'b0000, (i == 6) ? 4'b0100 : 4'b0000, 4'b0000);
        end

        // Release bounce on KEY[3]; hold count pauses while bouncing, so hold lands at c19
        applyStimulus(4'b0111);
        for (int i = 1; i <= 24; i++) begin
            @(negedge CLOCK_50);
            checkAll($sformatf("t4 bounce c%0d", i), (i >= 6) ? 4'b1000 : 4'b0000,
                     (i == 6) ? 4'b1000 : 4'b0000, 4'b0000, (i == 19) ? 4'b1000 : 4'b0000);
            if (i == 10) applyStimulus(4'b1111);
            if (i == 12) applyStimulus(4'b0111);
        end
        applyStimulus(4'b1111);
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLOCK_50);
            checkAll($sformatf("t4 release c%0d", i), (i < 6) ? 4'b1000 : 4'b0000,
                     4'b0000, (i == 6) ? 4'b1000 : 4'b0000, 4'b0000);
        end

        // Simultaneous press and release of KEY[0] and KEY[1]
        applyStimulus(4'b1100);
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLOCK_50);
            checkAll($sformatf("t5 press c%0d", i), (i >= 6) ? 4'b0011 : 4'b0000,
                     (i == 6) ? 4'b0011 : 4'b0000, 4'b0000, 4'b0000);
        end
        applyStimulus(4'b1111);
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLOCK_50);
            checkAll($sformatf("t5 release c%0d", i), (i < 6) ? 4'b0011 : 4'b0000,
                     4'b0000, (i == 6) ? 4'b0011 : 4'b0000, 4'b0000);
        end

        // Reset while KEY[2] is pressed and KEY[1] is mid-debounce
        applyStimulus(4'b1011);
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLOCK_50);
            checkAll($sformatf("t6 pre c%0d", i), (i >= 6) ? 4'b0100 : 4'b0000,
                     (i == 6) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0000);
        end
        applyStimulus(4'b1001);
        repeat (3) @(negedge CLOCK_50);
        checkAll("t6 debouncing", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        RESET_N = 1'b0;
        #1;
        checkAll("t6 reset async", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        @(negedge CLOCK_50);
        checkAll("t6 reset held", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        RESET_N = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLOCK_50);
            checkAll($sformatf("t6 post c%0d", i), (i >= 6) ? 4'b0110 : 4'b0000,
                     (i == 6) ? 4'b0110 : 4'b0000, 4'b0000, 4'b0000);
        end
        applyStimulus(4'b1111);
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLOCK_50);
            checkAll($sformatf("t6 release c%0d", i), (i < 6) ? 4'b0110 : 4'b0000,
                     4'b0000, (i == 6) ? 4'b0110 : 4'b0000, 4'b0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
